// File: rtl/instr_arbiter.sv
// Round-robin arbiter for three instruction sources feeding a router.
// Each grant runs IDLE -> ISSUE -> GAP; an illegal destination is dropped straight to GAP.
module instr_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       req,
   input  logic [WIDTH-1:0] instr_0,
   input  logic [WIDTH-1:0] instr_1,
   input  logic [WIDTH-1:0] instr_2,
   input  logic [1:0]       dest_0,
   input  logic [1:0]       dest_1,
   input  logic [1:0]       dest_2,
   output logic [2:0]       ack,
   output logic             new_instr,
   output logic [1:0]       enable,
   output logic [WIDTH-1:0] out_instr,
   output logic             busy,
   output logic             drop_err,
   output logic [15:0]      issue_count
);

   typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

   state_t           r_state;
   logic [1:0]       r_last_grant;
   logic [WIDTH-1:0] r_word;
   logic [1:0]       r_dest;
   logic [2:0]       r_ack;
   logic             r_new_instr;
   logic [1:0]       r_enable;
   logic [WIDTH-1:0] r_out_instr;
   logic             r_busy;
   logic             r_drop_err;
   logic [15:0]      r_issue_count;

   logic [1:0]       w_start;
   logic [2:0]       w_rot;
   logic [1:0]       w_off;
   logic [2:0]       w_sum;
   logic [1:0]       w_win;
   logic [WIDTH-1:0] w_instr;
   logic [1:0]       w_dest;

   // Rotate req so bit 0 is the first candidate after the last grant.
   always_comb begin
      w_start = (r_last_grant == 2'd2) ? 2'd0 : r_last_grant + 2'd1;
      case (w_start)
         2'd1:    w_rot = {req[0], req[2], req[1]};
         2'd2:    w_rot = {req[1], req[0], req[2]};
         default: w_rot = req;
      endcase
      if (w_rot[0])      w_off = 2'd0;
      else if (w_rot[1]) w_off = 2'd1;
      else               w_off = 2'd2;
      w_sum = {1'b0, w_start} + {1'b0, w_off};
      w_win = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[1:0];
      case (w_win)
         2'd1:    begin w_instr = instr_1; w_dest = dest_1; end
         2'd2:    begin w_instr = instr_2; w_dest = dest_2; end
         default: begin w_instr = instr_0; w_dest = dest_0; end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_last_grant  <= 2'd2;
         r_word        <= '0;
         r_dest        <= 2'b00;
         r_ack         <= 3'b000;
         r_new_instr   <= 1'b0;
         r_enable      <= 2'b00;
         r_out_instr   <= '0;
         r_busy        <= 1'b0;
         r_drop_err    <= 1'b0;
         r_issue_count <= 16'h0000;
      end else begin
         r_ack       <= 3'b000;
         r_new_instr <= 1'b0;
         r_enable    <= 2'b00;
         r_out_instr <= '0;
         r_drop_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (|req) begin
                  r_ack        <= 3'b001 << w_win;
                  r_last_grant <= w_win;
                  r_word       <= w_instr;
                  r_dest       <= w_dest;
                  r_busy       <= 1'b1;
                  if (w_dest == 2'b11) begin
                     r_drop_err <= 1'b1;
                     r_state    <= GAP;
                  end else begin
                     r_state    <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               r_new_instr   <= 1'b1;
               r_enable      <= r_dest;
               r_out_instr   <= r_word;
               r_issue_count <= r_issue_count + 16'h0001;
               r_busy        <= 1'b1;
               r_state       <= GAP;
            end
            GAP: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign ack         = r_ack;
   assign new_instr   = r_new_instr;
   assign enable      = r_enable;
   assign out_instr   = r_out_instr;
   assign busy        = r_busy;
   assign drop_err    = r_drop_err;
   assign issue_count = r_issue_count;

endmodule

// File: tb/tb_instr_arbiter.sv
// Bench for instr_arbiter: a cycle-timeline model (grant cycle, strobe cycle, free cycle)
// checked every negedge, plus directed scenarios with literal expectations.
module tb_instr_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  req;
   logic [31:0] instr_0, instr_1, instr_2;
   logic [1:0]  dest_0, dest_1, dest_2;
   logic [2:0]  ack;
   logic        new_instr;
   logic [1:0]  enable;
   logic [31:0] out_instr;
   logic        busy;
   logic        drop_err;
   logic [15:0] issue_count;

   instr_arbiter #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .req(req),
      .instr_0(instr_0), .instr_1(instr_1), .instr_2(instr_2),
      .dest_0(dest_0), .dest_1(dest_1), .dest_2(dest_2),
      .ack(ack), .new_instr(new_instr), .enable(enable), .out_instr(out_instr),
      .busy(busy), .drop_err(drop_err), .issue_count(issue_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Expected outputs for the cycle following each rising edge, kept in a 4-deep ring.
   typedef struct {
      logic [2:0]  ack;
      logic        strb;
      logic [1:0]  en;
      logic [31:0] word;
      logic        busy;
      logic        drop;
   } slot_t;

   slot_t       sl [4];
   int          cyc = 0;
   int          free_at = 0;
   int          m_lg = 2;
   logic [15:0] m_cnt = 16'h0;
   logic        preload = 1'b0;

   task automatic model_clear();
      for (int i = 0; i < 4; i++) sl[i] = '{default: '0};
      m_lg = 2; m_cnt = 16'h0; free_at = 0;
   endtask

   task automatic model_step();
      int k, w;
      logic [1:0]  d  [3];
      logic [31:0] wd [3];
      if (!rst_n) begin
         model_clear();
         return;
      end
      d[0] = dest_0; d[1] = dest_1; d[2] = dest_2;
      wd[0] = instr_0; wd[1] = instr_1; wd[2] = instr_2;
      cyc++;
      k = cyc % 4;
      sl[(cyc + 1) % 4] = '{default: '0};
      if (preload) m_cnt = 16'hFFFE;
      if (cyc >= free_at && req != 3'b000) begin
         w = -1;
         for (int i = 0; i < 3; i++) begin
            int c;
            c = (m_lg + 1 + i) % 3;
            if (w < 0 && req[c]) w = c;
         end
         m_lg = w;
         sl[k].ack  = 3'b001 << w;
         sl[k].busy = 1'b1;
         if (d[w] == 2'b11) begin
            sl[k].drop = 1'b1;
            free_at = cyc + 2;
         end else begin
            sl[(cyc + 1) % 4].busy = 1'b1;
            sl[(cyc + 1) % 4].strb = 1'b1;
            sl[(cyc + 1) % 4].en   = d[w];
            sl[(cyc + 1) % 4].word = wd[w];
            free_at = cyc + 3;
         end
      end
      if (sl[k].strb) m_cnt++;
   endtask

   initial begin
      model_clear();
      forever begin
         @(posedge clk or negedge rst_n);
         model_step();
      end
   end

   initial begin
      forever begin
         int k;
         @(negedge clk);
         k = cyc % 4;
         chk("m_ack",      32'(ack),         32'(sl[k].ack));
         chk("m_new",      32'(new_instr),   32'(sl[k].strb));
         chk("m_enable",   32'(enable),      32'(sl[k].en));
         chk("m_out",      out_instr,        sl[k].word);
         chk("m_busy",     32'(busy),        32'(sl[k].busy));
         chk("m_drop",     32'(drop_err),    32'(sl[k].drop));
         chk("m_count",    32'(issue_count), 32'(m_cnt));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [2:0] rot [4];
      rot[0] = 3'b001; rot[1] = 3'b010; rot[2] = 3'b100; rot[3] = 3'b001;
      rst_n = 1'b0; req = 3'b000;
      instr_0 = '0; instr_1 = '0; instr_2 = '0;
      dest_0 = 2'b00; dest_1 = 2'b00; dest_2 = 2'b00;
      tick(2);
      chk("rst_ack",   32'(ack), 0);
      chk("rst_busy",  32'(busy), 0);
      chk("rst_count", 32'(issue_count), 0);
      rst_n = 1'b1;
      tick(1);

      // single request, self destination
      req = 3'b001; instr_0 = 32'hDEADBEEF; dest_0 = 2'b01;
      tick(1);
      chk("single_ack", 32'(ack), 32'(3'b001));
      req = 3'b000;
      tick(1);
      chk("single_new", 32'(new_instr), 1);
      chk("single_out", out_instr, 32'hDEADBEEF);
      chk("single_en",  32'(enable), 32'(2'b01));
      chk("single_cnt", 32'(issue_count), 1);
      tick(2);

      // contention: all three held after reset
      pulse_reset();
      req = 3'b111; dest_0 = 2'b00; dest_1 = 2'b00; dest_2 = 2'b00;
      instr_0 = 32'hA0A0A0A0; instr_1 = 32'hA1A1A1A1; instr_2 = 32'hA2A2A2A2;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         chk("rr_ack", 32'(ack), 32'(rot[i]));
         tick(2);
      end
      req = 3'b000;
      tick(3);

      // illegal destination is dropped
      req = 3'b010; instr_1 = 32'hBAD1BAD1; dest_1 = 2'b11;
      tick(1);
      chk("drop_ack", 32'(ack), 32'(3'b010));
      chk("drop_err", 32'(drop_err), 1);
      req = 3'b000;
      tick(1);
      chk("drop_nonew", 32'(new_instr), 0);
      chk("drop_cnt",   32'(issue_count), 4);
      tick(2);

      // reset while the strobe is out
      req = 3'b001; instr_0 = 32'hC0C0C0C0; dest_0 = 2'b00;
      tick(1);
      req = 3'b000;
      tick(1);
      chk("abort_pre_new", 32'(new_instr), 1);
      #2 rst_n = 1'b0;
      #1 chk("abort_new", 32'(new_instr), 0);
      chk("abort_cnt", 32'(issue_count), 0);
      tick(1);
      rst_n = 1'b1; req = 3'b100; instr_2 = 32'hE2E2E2E2; dest_2 = 2'b10;
      tick(1);
      chk("abort_ack2", 32'(ack), 32'(3'b100));
      req = 3'b000;
      tick(1);
      chk("abort_out", out_instr, 32'hE2E2E2E2);
      chk("abort_cnt1", 32'(issue_count), 1);
      tick(2);

      // late request from requester 2 while requester 0 is issuing
      req = 3'b001; instr_0 = 32'h00000F00; dest_0 = 2'b01;
      tick(1);
      chk("late_ack0", 32'(ack), 32'(3'b001));
      req = 3'b101;
      tick(1);
      chk("late_noack_a", 32'(ack), 0);
      tick(1);
      chk("late_noack_b", 32'(ack), 0);
      tick(1);
      chk("late_ack2", 32'(ack), 32'(3'b100));
      req = 3'b001;
      tick(3);
      chk("late_ack0b", 32'(ack), 32'(3'b001));
      req = 3'b000;
      tick(3);

      // mixed drop / issue rotation
      req = 3'b110; dest_1 = 2'b11; dest_2 = 2'b01;
      instr_1 = 32'h11111111; instr_2 = 32'h22222222;
      tick(10);
      req = 3'b000;
      tick(4);

      // counter wrap from a preloaded value
      force dut.r_issue_count = 16'hFFFE;
      preload = 1'b1;
      tick(1);
      preload = 1'b0;
      release dut.r_issue_count;
      chk("wrap_pre", 32'(issue_count), 32'h0000FFFE);
      req = 3'b001; dest_0 = 2'b01; instr_0 = 32'h5A5A5A5A;
      tick(2);
      chk("wrap_ffff", 32'(issue_count), 32'h0000FFFF);
      tick(3);
      chk("wrap_zero", 32'(issue_count), 0);
      req = 3'b000;
      tick(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
